// File: rtl/cfg_pkg.sv
// Shared definitions for the AXI configuration slave: register map, response
// codes, channel FSM state types and byte-lane helpers.
package cfg_pkg;

  localparam logic [15:0] OFF_SCRATCH0 = 16'h0000;
  localparam logic [15:0] OFF_SCRATCH1 = 16'h0004;
  localparam logic [15:0] OFF_LED      = 16'h0010;
  localparam logic [15:0] OFF_SWITCH   = 16'h0014;
  localparam logic [15:0] OFF_NUM      = 16'h0018;
  localparam logic [15:0] OFF_TIMER    = 16'h0020;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{strb[i]}};
    return mask;
  endfunction

  // Bursts step the word index and wrap inside the 64 KiB window; the byte offset is kept.
  function automatic logic [15:0] next_beat_addr(input logic [15:0] addr);
    return {addr[15:2] + 14'd1, addr[1:0]};
  endfunction

endpackage

// File: rtl/cfg_regfile.sv
// Register storage for the configuration slave: decode, byte-masked write port,
// single combinational read port with hit flag, and the free-running timer.
module cfg_regfile
  import cfg_pkg::*;
#(
  parameter int          SW_WIDTH  = 16,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [15:0]         wr_addr,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_strb,
  output logic                wr_hit,
  input  logic [15:0]         rd_addr,
  output logic [31:0]         rd_data,
  output logic                rd_hit,
  input  logic [SW_WIDTH-1:0] switch_in,
  output logic [SW_WIDTH-1:0] led_out,
  output logic [31:0]         num_out
);

  logic [31:0]         scratch0;
  logic [31:0]         scratch1;
  logic [SW_WIDTH-1:0] led;
  logic [31:0]         num;
  logic [31:0]         timer;
  logic [31:0]         mask;

  assign mask    = strb_mask(wr_strb);
  assign led_out = led;
  assign num_out = num;

  // SWITCH is read-only, so a write there is treated like an unmapped one.
  always_comb begin
    // NOTE: defaults come first so every path assigns and no latch is inferred.
    wr_hit = 1'b0;
    case (wr_addr)
      OFF_SCRATCH0, OFF_SCRATCH1, OFF_LED, OFF_NUM, OFF_TIMER: wr_hit = 1'b1;
      default: wr_hit = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    rd_hit  = 1'b1;
    case (rd_addr)
      OFF_SCRATCH0: rd_data = scratch0;
      OFF_SCRATCH1: rd_data = scratch1;
      OFF_LED:      rd_data = 32'(led);
      OFF_SWITCH:   rd_data = 32'(switch_in);
      OFF_NUM:      rd_data = num;
      OFF_TIMER:    rd_data = timer;
      default: begin
        rd_data = 32'h0;
        rd_hit  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch0 <= 32'h0;
      scratch1 <= 32'h0;
      led      <= '0;
      num      <= 32'h0;
      timer    <= TIMER_RST;
    end else begin
      // NOTE: non-blocking updates; the later TIMER write assignment overrides this increment.
      timer <= timer + 32'd1;
      if (wr_en) begin
        case (wr_addr)
          OFF_SCRATCH0: scratch0 <= (scratch0 & ~mask) | (wr_data & mask);
          OFF_SCRATCH1: scratch1 <= (scratch1 & ~mask) | (wr_data & mask);
          OFF_LED:      led      <= (led & ~mask[SW_WIDTH-1:0]) |
                                    (wr_data[SW_WIDTH-1:0] & mask[SW_WIDTH-1:0]);
          OFF_NUM:      num      <= (num & ~mask) | (wr_data & mask);
          OFF_TIMER:    timer    <= (timer & ~mask) | (wr_data & mask);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/axi_cfg_slave.sv
// AXI burst slave in front of cfg_regfile: independent read and write channel
// FSMs, registered read data, sticky per-burst write error reporting.
module axi_cfg_slave
  import cfg_pkg::*;
#(
  parameter int          SW_WIDTH  = 16,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic                arvalid,
  output logic                arready,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [SW_WIDTH-1:0] switch_in,
  output logic [SW_WIDTH-1:0] led_out,
  output logic [31:0]         num_out
);

  r_state_t    r_state, r_state_next;
  logic [15:0] raddr;
  logic [7:0]  rcnt;
  logic        ar_hs, r_hs;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_hit;

  w_state_t    w_state, w_state_next;
  logic [15:0] waddr;
  logic [7:0]  wcnt;
  logic        werr;
  logic        aw_hs, w_hs, w_final, beat_err, wr_hit;

  // Transfer size and the upper address half play no part in decode.
  logic unused_inputs;
  assign unused_inputs = ^{araddr[31:16], awaddr[31:16], arsize, awsize};

  cfg_regfile #(
    .SW_WIDTH (SW_WIDTH),
    .TIMER_RST(TIMER_RST)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_hs),
    .wr_addr  (waddr),
    .wr_data  (wdata),
    .wr_strb  (wstrb),
    .wr_hit   (wr_hit),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .switch_in(switch_in),
    .led_out  (led_out),
    .num_out  (num_out)
  );

  // ---------------- read channel ----------------
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // While idle the port looks at the incoming address; during a burst it pre-reads the next beat.
  assign rd_addr = (r_state == R_IDLE) ? araddr[15:0] : next_beat_addr(raddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr <= 16'h0;
      rcnt  <= 8'h0;
      rdata <= 32'h0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
    end else if (ar_hs) begin
      raddr <= araddr[15:0];
      rcnt  <= arlen;
      rdata <= rd_data;
      rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      rlast <= (arlen == 8'd0);
    end else if (r_hs && !rlast) begin
      raddr <= next_beat_addr(raddr);
      rcnt  <= rcnt - 8'd1;
      rdata <= rd_data;
      rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      rlast <= (rcnt == 8'd1);
    end else if (r_hs) begin
      rlast <= 1'b0;
    end
  end

  // ---------------- write channel ----------------
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign w_final = (wcnt == 8'd0);
  // The beat counter alone ends the burst; wlast is only checked against it.
  assign beat_err = ~wr_hit | (wlast != w_final);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr <= 16'h0;
      wcnt  <= 8'h0;
      werr  <= 1'b0;
      bresp <= RESP_OKAY;
    end else if (aw_hs) begin
      waddr <= awaddr[15:0];
      wcnt  <= awlen;
      werr  <= 1'b0;
    end else if (w_hs) begin
      waddr <= next_beat_addr(waddr);
      wcnt  <= wcnt - 8'd1;
      werr  <= werr | beat_err;
      if (w_final) bresp <= (werr | beat_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_cfg_slave.sv
// Bench for axi_cfg_slave: constant vector table, directed burst/corner
// sequences, then random traffic against a register-map reference model.
module tb_axi_cfg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] switch_in = 16'hBEEF;
  logic [15:0] led_out;
  logic [31:0] num_out;

  axi_cfg_slave #(.SW_WIDTH(16), .TIMER_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .switch_in(switch_in), .led_out(led_out), .num_out(num_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: register contents; timer = m_tbase after edge m_tcyc, +1 per later edge.
  logic [31:0] m_scr0, m_scr1, m_num, m_tbase;
  logic [15:0] m_led;
  int unsigned m_tcyc;

  function automatic void m_reset();
    m_scr0 = 0; m_scr1 = 0; m_num = 0; m_led = 0;
    m_tbase = 32'h0; m_tcyc = cyc;
  endfunction

  // Value visible just before clock edge number k.
  function automatic logic [31:0] m_timer(input int unsigned k);
    return m_tbase + 32'(k - 1 - m_tcyc);
  endfunction

  function automatic logic [33:0] m_read(input logic [15:0] a, input int unsigned k);
    case (a)
      16'h0000: return {2'b00, m_scr0};
      16'h0004: return {2'b00, m_scr1};
      16'h0010: return {2'b00, 16'h0, m_led};
      16'h0014: return {2'b00, 16'h0, switch_in};
      16'h0018: return {2'b00, m_num};
      16'h0020: return {2'b00, m_timer(k)};
      default:  return {2'b10, 32'h0};
    endcase
  endfunction

  // Applies a beat landing on edge k; returns 0 when the target is not writable.
  function automatic bit m_write(input logic [15:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int unsigned k);
    logic [31:0] m, t;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
    case (a)
      16'h0000: m_scr0 = (m_scr0 & ~m) | (d & m);
      16'h0004: m_scr1 = (m_scr1 & ~m) | (d & m);
      16'h0010: begin t = {16'h0, m_led}; t = (t & ~m) | (d & m); m_led = t[15:0]; end
      16'h0018: m_num = (m_num & ~m) | (d & m);
      16'h0020: begin m_tbase = (m_timer(k) & ~m) | (d & m); m_tcyc = k; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rd_got [16];
  logic [1:0]  rs_got [16];
  logic        rl_got [16];
  logic [15:0] rd_a [16];
  int unsigned rd_edge [16];

  task automatic axi_write(input logic [31:0] addr, input int len, input int bad_beat,
                           output logic [1:0] got, output logic [1:0] exp);
    logic [15:0] a;
    bit err;
    int t;
    got = 2'bxx; exp = 2'b00; err = 0;
    awaddr = addr; awlen = 8'(len); awsize = 3'd2; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(negedge clk); t++; end
    check("awready wait", 32'(awready), 32'd1);
    if (!awready) begin awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    a = addr[15:0];
    for (int b = 0; b <= len; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b];
      wlast = (b == len) ^ (b == bad_beat);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 20) begin @(negedge clk); t++; end
      check("wready wait", 32'(wready), 32'd1);
      if (!wready) begin wvalid = 1'b0; return; end
      if (!m_write(a, wbuf[b], sbuf[b], cyc + 1) || (b == bad_beat)) err = 1;
      a = {a[15:2] + 14'd1, a[1:0]};
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    check("bvalid wait", 32'(bvalid), 32'd1);
    if (!bvalid) return;
    got = bresp;
    exp = err ? 2'b10 : 2'b00;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input int stall_beat,
                          input int stall_n);
    logic [15:0] a;
    int t;
    a = addr[15:0];
    for (int b = 0; b < 16; b++) begin rd_got[b] = 'x; rs_got[b] = 'x; rl_got[b] = 'x; end
    araddr = addr; arlen = 8'(len); arsize = 3'd2; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    check("arready wait", 32'(arready), 32'd1);
    if (!arready) begin arvalid = 1'b0; return; end
    rd_edge[0] = cyc + 1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      t = 0;
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      check("rvalid wait", 32'(rvalid), 32'd1);
      if (!rvalid) return;
      rd_got[b] = rdata; rs_got[b] = rresp; rl_got[b] = rlast; rd_a[b] = a;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall rvalid", 32'(rvalid), 32'd1);
          check("stall rdata", rdata, rd_got[b]);
          check("stall rresp", 32'(rresp), 32'(rs_got[b]));
          check("stall rlast", 32'(rlast), 32'(rl_got[b]));
        end
      end
      rready = 1'b1;
      if (b < len) rd_edge[b+1] = cyc + 1;
      a = {a[15:2] + 14'd1, a[1:0]};
      @(negedge clk);
      rready = 1'b0;
    end
    check("rvalid after burst", 32'(rvalid), 32'd0);
  endtask

  task automatic check_read_model(input string tag, input int len);
    logic [33:0] e;
    for (int b = 0; b <= len; b++) begin
      e = m_read(rd_a[b], rd_edge[b]);
      check($sformatf("%s rdata b%0d @%h", tag, b, rd_a[b]), rd_got[b], e[31:0]);
      check($sformatf("%s rresp b%0d", tag, b), 32'(rs_got[b]), 32'(e[33:32]));
      check($sformatf("%s rlast b%0d", tag, b), 32'(rl_got[b]), 32'(b == len));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " arready"}, 32'(arready), 32'd1);
    check({tag, " awready"}, 32'(awready), 32'd1);
    check({tag, " rvalid"},  32'(rvalid),  32'd0);
    check({tag, " wready"},  32'(wready),  32'd0);
    check({tag, " bvalid"},  32'(bvalid),  32'd0);
    check({tag, " rlast"},   32'(rlast),   32'd0);
    check({tag, " rdata"},   rdata,        32'd0);
    check({tag, " rresp"},   32'(rresp),   32'd0);
    check({tag, " bresp"},   32'(bresp),   32'd0);
    check({tag, " led_out"}, 32'(led_out), 32'd0);
    check({tag, " num_out"}, num_out,      32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  got, expm;
    logic [15:0] offs [10];
    logic [15:0] off;
    int          len, bad;

    vecs[0]  = '{1'b1, 32'h0000, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 16'h0000, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 16'h0000, 32'h0};
    vecs[2]  = '{1'b1, 32'h0018, 32'h12345678, 4'h5, 32'h0,        2'b00, 16'h0000, 32'h00340078};
    vecs[3]  = '{1'b0, 32'h0018, 32'h0,        4'h0, 32'h00340078, 2'b00, 16'h0000, 32'h00340078};
    vecs[4]  = '{1'b1, 32'h0014, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 16'h0000, 32'h00340078};
    vecs[5]  = '{1'b1, 32'h0100, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 16'h0000, 32'h00340078};
    vecs[6]  = '{1'b0, 32'h0100, 32'h0,        4'h0, 32'h0,        2'b10, 16'h0000, 32'h00340078};
    vecs[7]  = '{1'b1, 32'h0010, 32'hA5A51234, 4'hF, 32'h0,        2'b00, 16'h1234, 32'h00340078};
    vecs[8]  = '{1'b0, 32'h0010, 32'h0,        4'h0, 32'h00001234, 2'b00, 16'h1234, 32'h00340078};
    vecs[9]  = '{1'b0, 32'h0014, 32'h0,        4'h0, 32'h0000BEEF, 2'b00, 16'h1234, 32'h00340078};
    vecs[10] = '{1'b1, 32'h0004, 32'hCAFEF00D, 4'h8, 32'h0,        2'b00, 16'h1234, 32'h00340078};
    vecs[11] = '{1'b0, 32'h0004, 32'h0,        4'h0, 32'hCA000000, 2'b00, 16'h1234, 32'h00340078};
    vecs[12] = '{1'b0, 32'h0003, 32'h0,        4'h0, 32'h0,        2'b10, 16'h1234, 32'h00340078};
    vecs[13] = '{1'b1, 32'h0010, 32'h00005600, 4'h2, 32'h0,        2'b00, 16'h5634, 32'h00340078};
    vecs[14] = '{1'b0, 32'h0000, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 16'h5634, 32'h00340078};

    // Power-on reset.
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    m_reset();

    // Single-beat vector table from the reset state.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        wbuf[0] = vecs[i].data; sbuf[0] = vecs[i].strb;
        axi_write(vecs[i].addr, 0, -1, got, expm);
        check($sformatf("vec%0d bresp", i), 32'(got), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 0, -1, 0);
        check($sformatf("vec%0d rdata", i), rd_got[0], vecs[i].exp_data);
        check($sformatf("vec%0d rresp", i), 32'(rs_got[0]), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d rlast", i), 32'(rl_got[0]), 32'd1);
      end
      check($sformatf("vec%0d led_out", i), 32'(led_out), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d num_out", i), num_out, vecs[i].exp_num);
    end

    // Four-beat read with a three-cycle stall on the first beat.
    axi_read(32'h0000, 3, 0, 3);
    check("burst b0 data", rd_got[0], 32'hDEADBEEF);
    check("burst b1 data", rd_got[1], 32'hCA000000);
    check("burst b2 data", rd_got[2], 32'h0);
    check("burst b3 data", rd_got[3], 32'h0);
    check("burst b0 resp", 32'(rs_got[0]), 32'd0);
    check("burst b1 resp", 32'(rs_got[1]), 32'd0);
    check("burst b2 resp", 32'(rs_got[2]), 32'd2);
    check("burst b3 resp", 32'(rs_got[3]), 32'd2);
    check("burst rlast", 32'({rl_got[0], rl_got[1], rl_got[2], rl_got[3]}), 32'b0001);

    // wlast mismatches make the whole burst SLVERR; a clean burst afterwards is OKAY.
    wbuf[0] = 32'h01010101; wbuf[1] = 32'h02020202; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    axi_write(32'h0000, 1, 0, got, expm);
    check("early wlast bresp", 32'(got), 32'd2);
    axi_write(32'h0018, 1, 1, got, expm);
    check("missing wlast bresp", 32'(got), 32'd2);
    axi_write(32'h0000, 1, -1, got, expm);
    check("clean burst bresp", 32'(got), 32'd0);
    axi_read(32'h0000, 1, -1, 0);
    check_read_model("post-burst", 1);

    // A read captured on the same edge as a write to that register sees the old value.
    wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
    axi_write(32'h0000, 0, -1, got, expm);
    wbuf[0] = 32'h22222222;
    fork
      axi_write(32'h0000, 0, -1, got, expm);
      begin
        @(negedge clk);
        axi_read(32'h0000, 0, -1, 0);
      end
    join
    check("same-edge read old", rd_got[0], 32'h11111111);
    check("same-edge bresp", 32'(got), 32'd0);
    axi_read(32'h0000, 0, -1, 0);
    check("after same-edge write", rd_got[0], 32'h22222222);

    // Timer wrap; captured value is held through a stalled rready.
    wbuf[0] = 32'hFFFFFFFE; sbuf[0] = 4'hF;
    axi_write(32'h0020, 0, -1, got, expm);
    check("timer write bresp", 32'(got), 32'd0);
    axi_read(32'h0020, 0, 0, 4);
    check_read_model("timer near wrap", 0);
    axi_read(32'h0020, 0, -1, 0);
    check_read_model("timer wrapped", 0);
    check("timer wrapped small", 32'(rd_got[0] < 32'h10), 32'd1);

    // Asynchronous reset while a read beat and a write response are both pending.
    arvalid = 1'b1; araddr = 32'h0; arlen = 8'd3;
    awvalid = 1'b1; awaddr = 32'h4; awlen = 8'd0; rready = 1'b0; bready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h33333333; wstrb = 4'hF; wlast = 1'b1;
    check("pre-reset wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    check("pre-reset rvalid", 32'(rvalid), 32'd1);
    check("pre-reset bvalid", 32'(bvalid), 32'd1);
    check("pre-reset rdata", rdata, m_scr0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid-burst reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    wbuf[0] = 32'h5A5AA5A5; sbuf[0] = 4'hF;
    axi_write(32'h0004, 0, -1, got, expm);
    check("post-reset bresp", 32'(got), 32'd0);
    axi_read(32'h0000, 1, -1, 0);
    check("post-reset scratch0", rd_got[0], 32'h0);
    check("post-reset scratch1", rd_got[1], 32'h5A5AA5A5);
    axi_read(32'h0020, 0, -1, 0);
    check_read_model("post-reset timer", 0);

    // Random bursts against the reference model.
    offs = '{16'h0000, 16'h0004, 16'h0010, 16'h0014, 16'h0018,
             16'h0020, 16'h000C, 16'h0100, 16'hFFFC, 16'h001C};
    for (int it = 0; it < 80; it++) begin
      switch_in = 16'($urandom);
      off = offs[$urandom_range(9, 0)];
      len = int'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wbuf[b] = $urandom;
          sbuf[b] = 4'($urandom);
        end
        bad = ($urandom_range(4, 0) == 0) ? int'($urandom_range(len, 0)) : -1;
        axi_write({16'($urandom), off}, len, bad, got, expm);
        check($sformatf("rand%0d bresp @%h", it, off), 32'(got), 32'(expm));
      end else begin
        axi_read({16'($urandom), off}, len, int'($urandom_range(len, 0)),
                 int'($urandom_range(3, 0)));
        check_read_model($sformatf("rand%0d", it), len);
      end
      check($sformatf("rand%0d led_out", it), 32'(led_out), 32'(m_led));
      check($sformatf("rand%0d num_out", it), num_out, m_num);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_cfg_slave.md
AXI_CFG_SLAVE -- requirements
Module: axi_cfg_slave

Interface
REQ-001 Parameter: SW_WIDTH, 16, width of switch input and LED output.
REQ-002 Parameter: TIMER_RST, 32'h0, timer value after reset.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 araddr in 32, arlen in 8, arsize in 3, arvalid in 1, arready out 1: AXI read address channel.
REQ-006 rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1: AXI read data channel.
REQ-007 awaddr in 32, awlen in 8, awsize in 3, awvalid in 1, awready out 1: AXI write address channel.
REQ-008 wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1: AXI write data channel.
REQ-009 bresp out 2, bvalid out 1, bready in 1: AXI write response channel.
REQ-010 switch_in in SW_WIDTH, led_out out SW_WIDTH, num_out out 32: board I/O.

Function
REQ-011 Decode uses addr[15:0]: 0x0000 SCRATCH0 RW32, 0x0004 SCRATCH1 RW32, 0x0010 LED RW[SW_WIDTH-1:0], 0x0014 SWITCH RO, 0x0018 NUM RW32, 0x0020 TIMER RW32; any other offset is unmapped.
REQ-012 Unmapped read returns rdata 0, rresp SLVERR (2'b10); unmapped or SWITCH write discards data, forces bresp SLVERR; mapped accesses return OKAY (2'b00).
REQ-013 Read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE; arvalid&arready captures araddr, arlen, enters R_DATA.
REQ-014 Read latency: address handshake in cycle N -> rvalid=1 in cycle N+1 with registered rdata/rresp.
REQ-015 rdata, rresp, rlast SHALL stay stable while rvalid&~rready (timer ticking must not change held rdata).
REQ-016 Each rvalid&rready advances addr[15:2] by 1 (wraps mod 2^14, addr[1:0] kept), decrements beat count, reloads rdata; rlast=1 when remaining count is 0; handshake on rlast returns to R_IDLE.
REQ-017 Write FSM states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; handshake captures awaddr, awlen, enters W_DATA.
REQ-018 In W_DATA wready=1; each wvalid&wready writes byte lanes where wstrb[i]=1, then advances address as REQ-016.
REQ-019 Burst ends on beat count (awlen+1), not wlast; wlast mismatch on any beat forces bresp SLVERR; error is sticky across the burst.
REQ-020 Final beat -> W_RESP, bvalid=1 with bresp held until bvalid&bready, then W_IDLE.
REQ-021 Read and write FSMs run independently; same-cycle read capture and write of same register: read captures pre-write value.
REQ-022 TIMER increments by 1 every cycle, wraps 0xFFFFFFFF -> 0; a write cycle loads masked data and suppresses that cycle's increment.
REQ-023 arsize/awsize are ignored; byte selection solely by wstrb.
REQ-024 led_out, num_out driven directly from LED, NUM registers.

Reset
REQ-025 On rst low (asynchronous): both FSMs idle, arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0.
REQ-026 On reset: SCRATCH0/1, LED, NUM = 0; TIMER = TIMER_RST; in-flight bursts abandoned without response.

Structure
REQ-027 Shared package cfg_pkg holds register offsets, response codes (OKAY, SLVERR), read/write FSM state encodings.
REQ-028 One sub-module cfg_regfile: register storage, address decode, byte-masked write port, one read port returning data plus hit flag, timer counter.

Verification
REQ-029 Write 0xDEADBEEF to 0x0000, wstrb 4'b1111, awlen 0 -> bresp OKAY; read 0x0000 -> rdata 0xDEADBEEF, rresp OKAY, rlast 1.
REQ-030 Write 0x12345678 to 0x0018, wstrb 4'b0101 after NUM=0 -> num_out 0x00340078.
REQ-031 Read burst araddr 0x0000, arlen 3, rready held low 3 cycles on beat 1 -> beats SCRATCH0, SCRATCH1, 0/SLVERR, 0/SLVERR; rlast only on beat 4; data stable during stall.
REQ-032 Write TIMER 0xFFFFFFFE, read two cycles after write -> timer wraps to 0x0/0x1 region; value captured at address handshake held until rready.
REQ-033 Write 0x0014 or 0x0100 -> bresp SLVERR, registers unchanged; awlen 1 with wlast on beat 1 -> bresp SLVERR.
REQ-034 Assert rst low mid-burst (rvalid=1, bvalid=1) -> outputs immediately per REQ-025; next transaction completes normally.
